// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multicycle RV32I sequencer; owns PC, IR, the imem/dmem handshakes,
// register-file write strobes, the sticky trap flag and the retired-instruction counter.
module core_seq_ctrl #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] inst_o,
   input  logic [6:0]  opcode_i,
   input  logic        branch_taken_i,
   input  logic [31:0] target_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   input  logic        dmem_ack_i,
   output logic [31:0] pc_o,
   output logic        rf_we_o,
   output logic [1:0]  rf_wsel_o,
   output logic        trap_o,
   output logic [31:0] instret_o
);
   typedef enum logic [2:0] {BOOT, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_e;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_MISC   = 7'b0001111;
   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, inst_q, inst_d, instret_q, instret_d, target_q, target_d;
   logic [6:0]  op_q, op_d;
   logic        redir_q, redir_d;
   logic        legal, is_jump, is_load, is_store, redir_now, wen;
   // The opcode is captured in DECODE so every output derives from registered values only.
   always_comb begin
      legal     = opcode_i inside {OP_LUI, OP_AUIPC, OP_IMM, OP_OP, OP_JAL, OP_JALR,
                                   OP_BRANCH, OP_LOAD, OP_STORE, OP_MISC};
      is_jump   = op_q == OP_JAL || op_q == OP_JALR;
      is_load   = op_q == OP_LOAD;
      is_store  = op_q == OP_STORE;
      redir_now = is_jump || (op_q == OP_BRANCH && branch_taken_i);
      wen       = op_q inside {OP_LUI, OP_AUIPC, OP_IMM, OP_OP, OP_JAL, OP_JALR, OP_LOAD};
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      instret_d = instret_q;
      target_d  = target_q;
      op_d      = op_q;
      redir_d   = redir_q;
      case (state_q)
         BOOT:    state_d = FETCH;
         FETCH: begin
            inst_d  = imem_ack_i ? imem_rdata_i : inst_q;
            state_d = imem_ack_i ? DECODE : FETCH;
         end
         DECODE: begin
            op_d    = opcode_i;
            state_d = legal ? EXEC : TRAP;
         end
         EXEC: begin
            redir_d  = redir_now;
            target_d = redir_now ? target_i : target_q;
            state_d  = (redir_now && target_i[1:0] != 2'b00) ? TRAP :
                       (is_load || is_store) ? MEM : WB;
         end
         MEM:     state_d = dmem_ack_i ? WB : MEM;
         WB: begin
            pc_d      = redir_q ? target_q : pc_q + 32'd4;
            instret_d = instret_q + 32'd1;
            state_d   = FETCH;
         end
         TRAP:    state_d = TRAP;
         default: state_d = BOOT;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= BOOT;
         pc_q      <= BOOT_ADDR;
         inst_q    <= 32'h0000_0013;
         instret_q <= 32'd0;
         target_q  <= 32'd0;
         op_q      <= OP_IMM;
         redir_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         instret_q <= instret_d;
         target_q  <= target_d;
         op_q      <= op_d;
         redir_q   <= redir_d;
      end
   end
   assign imem_req_o  = state_q == FETCH;
   assign imem_addr_o = pc_q;
   assign inst_o      = inst_q;
   assign dmem_req_o  = state_q == MEM;
   assign dmem_we_o   = dmem_req_o && is_store;
   assign pc_o        = pc_q;
   assign rf_we_o     = state_q == WB && wen;
   assign rf_wsel_o   = !rf_we_o ? 2'd0 : is_jump ? 2'd2 : is_load ? 2'd1 : 2'd0;
   assign trap_o      = state_q == TRAP;
   assign instret_o   = instret_q;
endmodule
